sig_dac_out: RTL and testbench
==============================

Name: sig_dac_out

Overview:
Output stage directly downstream of the sig_delay / sig_combine chain. Accepts the chain's sparse strobed sample stream (in_valid qualifies each sample) into a small elastic FIFO. Re-times samples onto the DAC's regular sample tick (dac_stb) and converts two's-complement samples to DAC code. Detects and counts overflow and underflow, and re-primes the FIFO after an underflow so the DAC always sees a defined level.

Parameters:
WIDTH, 12, sample width in bits (input and DAC code).
FIFO_LOG2, 4, log2 of FIFO depth (default depth 16).
PRIME, 8, FIFO level required before playout starts; legal range 1..2^FIFO_LOG2.
OFFSET_BIN, 1, 1 = output offset binary (MSB inverted); 0 = output two's complement unchanged.

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  reset, asynchronous, active-low
in_data  in  WIDTH  two's-complement sample from the combine stage
in_valid  in  1  in_data valid this cycle (one sample per high cycle)
dac_stb  in  1  DAC sample tick, single-cycle pulse, arbitrary spacing (may be every cycle)
dac_data  out  WIDTH  registered DAC code
dac_active  out  1  1 while in RUN state
fill  out  FIFO_LOG2+1  current FIFO occupancy, 0..2^FIFO_LOG2
ovf_cnt  out  16  dropped-input counter, saturating
udf_cnt  out  16  underflow-event counter, saturating
clr_cnt  in  1  synchronous clear of ovf_cnt and udf_cnt

Behaviour:
- Reset (rst_n low, async):
  - FIFO empty, fill=0, state IDLE, dac_active=0, ovf_cnt=0, udf_cnt=0.
  - dac_data = ZERO code: 2^(WIDTH-1) if OFFSET_BIN=1 (0x800 at 12 bits), else 0.
  - Reset mid-operation discards all FIFO contents; no partial state survives.
- FIFO: depth 2^FIFO_LOG2, read/write pointers are FIFO_LOG2+1 bits and wrap naturally.
  - Push when in_valid=1 and the FIFO is not full, or when full and a pop happens in the same cycle.
  - Push when full with no pop: sample dropped, ovf_cnt+1.
  - fill reflects the combined effect of push and pop; it is registered and valid one cycle after the event.
- State IDLE:
  - dac_data held at ZERO code, no pops.
  - On dac_stb with fill >= PRIME (fill value before this cycle): pop one sample, go to RUN, dac_active=1 next cycle.
- State RUN, on each dac_stb:
  - fill>0 (value before this cycle): pop. dac_data next cycle = sample, with MSB inverted if OFFSET_BIN=1.
  - fill==0: underflow. dac_data next cycle = ZERO code, udf_cnt+1, go to IDLE (re-prime). A push in the same cycle is still written; it does not rescue the underflow.
- Between dac_stb pulses, dac_data holds its value.
- Latency: dac_data changes exactly 1 clk after the dac_stb cycle. Minimum input-to-output latency is PRIME samples of buffering.
- Counters:
  - Saturate at 0xFFFF.
  - clr_cnt=1 forces both counters to 0 that cycle; clear wins over a simultaneous increment.
- Ordering: samples leave the FIFO in arrival order. No sample is duplicated. Samples are lost only by overflow drop.

Test Plan:
- Reset then idle: rst_n low 3 cycles, then high; no in_valid, dac_stb every 4 cycles -> dac_data=0x800, dac_active=0, fill=0, counters 0.
- Prime and playout: push 0x001..0x008 (in_valid every cycle), then dac_stb every 2 cycles -> dac_active rises 1 cycle after first stb. dac_data sequence 0x801,0x802,...,0x808, each 1 cycle after its stb.
- Underflow: continue the previous case with no further input; 9th stb -> dac_data=0x800, udf_cnt=1, state IDLE. Next stb with fill<8 -> dac_data stays 0x800.
- Overflow: with no dac_stb, push 20 samples 0x000..0x013 -> fill=16, ovf_cnt=4. Subsequent playout yields 0x800..0x80F; 0x010..0x013 are lost.
- Full with simultaneous push/pop: FIFO full in RUN, in_valid and dac_stb in the same cycle -> fill stays 16, ovf_cnt unchanged, new sample appears 16 pops later.
- OFFSET_BIN=0 and counter control: push 0xFFF (-1) x8 and play out -> dac_data=0xFFF. Underflow with clr_cnt in the same cycle -> udf_cnt=0. Forcing 65540 underflows -> udf_cnt=0xFFFF.

Source files
------------

// File: rtl/sig_dac_out.sv
// DAC output stage: elastic FIFO that re-times a strobed sample stream onto the
// DAC sample tick, with priming, under/overflow counting and offset-binary coding.
module sig_dac_out #(
  parameter int WIDTH      = 12,
  parameter int FIFO_LOG2  = 4,
  parameter int PRIME      = 8,
  parameter int OFFSET_BIN = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_valid,
  input  logic                 dac_stb,
  output logic [WIDTH-1:0]     dac_data,
  output logic                 dac_active,
  output logic [FIFO_LOG2:0]   fill,
  output logic [15:0]          ovf_cnt,
  output logic [15:0]          udf_cnt,
  input  logic                 clr_cnt
);

  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam logic [FIFO_LOG2:0] PRIME_LVL = PRIME[FIFO_LOG2:0];
  localparam logic [FIFO_LOG2:0] PTR_ONE   = {{FIFO_LOG2{1'b0}}, 1'b1};
  localparam logic               MSB_FLIP  = (OFFSET_BIN != 0);
  localparam logic [WIDTH-1:0]   ZERO_CODE = MSB_FLIP ? {1'b1, {(WIDTH-1){1'b0}}}
                                                      : {WIDTH{1'b0}};

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state_reg, state_next;
  logic [WIDTH-1:0]     mem [DEPTH];
  logic [FIFO_LOG2:0]   wr_ptr_reg, rd_ptr_reg, fill_reg;
  logic [WIDTH-1:0]     dac_reg;
  logic [15:0]          ovf_reg, udf_reg;
  logic                 pop, underflow, push, drop, full, empty;
  logic [WIDTH-1:0]     rd_data;

  assign full    = fill_reg[FIFO_LOG2];
  assign empty   = (fill_reg == '0);
  assign rd_data = mem[rd_ptr_reg[FIFO_LOG2-1:0]];

  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    underflow  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (dac_stb && (fill_reg >= PRIME_LVL)) begin
          pop        = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (dac_stb) begin
          if (!empty) begin
            pop = 1'b1;
          end else begin
            underflow  = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A full FIFO still accepts a sample when a slot is freed in the same cycle.
  assign push = in_valid && (!full || pop);
  assign drop = in_valid && full && !pop;

  // Storage carries no reset so it maps onto plain RAM; occupancy is tracked separately.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg[FIFO_LOG2-1:0]] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      fill_reg   <= '0;
      dac_reg    <= ZERO_CODE;
    end else begin
      state_reg <= state_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      case ({push, pop})
        2'b10:   fill_reg <= fill_reg + PTR_ONE;
        2'b01:   fill_reg <= fill_reg - PTR_ONE;
        default: fill_reg <= fill_reg;
      endcase
      if (pop) begin
        dac_reg <= {rd_data[WIDTH-1] ^ MSB_FLIP, rd_data[WIDTH-2:0]};
      end else if (underflow) begin
        dac_reg <= ZERO_CODE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_reg <= '0;
      udf_reg <= '0;
    end else if (clr_cnt) begin
      ovf_reg <= '0;
      udf_reg <= '0;
    end else begin
      if (drop && (ovf_reg != 16'hFFFF))      ovf_reg <= ovf_reg + 16'd1;
      if (underflow && (udf_reg != 16'hFFFF)) udf_reg <= udf_reg + 16'd1;
    end
  end

  assign dac_data   = dac_reg;
  assign dac_active = (state_reg == RUN);
  assign fill       = fill_reg;
  assign ovf_cnt    = ovf_reg;
  assign udf_cnt    = udf_reg;

endmodule

// File: tb/tb_sig_dac_out.sv
// Bench for sig_dac_out: two instances (offset-binary and two's-complement) share
// stimulus and are compared against a queue-based model of the playout rules.
module tb_sig_dac_out;

  localparam int DEPTH = 16;
  localparam int PRIME = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        dac_stb = 1'b0;
  logic        clr_cnt = 1'b0;

  logic [11:0] dac_data0, dac_data1;
  logic        dac_active0, dac_active1;
  logic [4:0]  fill0, fill1;
  logic [15:0] ovf0, ovf1, udf0, udf1;

  int tests = 0;
  int fails = 0;

  // model state
  logic [11:0] q[$];
  bit          m_run;
  int          m_ovf, m_udf;
  logic [11:0] m_dac0, m_dac1;

  sig_dac_out #(.WIDTH(12), .FIFO_LOG2(4), .PRIME(8), .OFFSET_BIN(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .dac_stb(dac_stb), .dac_data(dac_data0), .dac_active(dac_active0),
    .fill(fill0), .ovf_cnt(ovf0), .udf_cnt(udf0), .clr_cnt(clr_cnt));

  sig_dac_out #(.WIDTH(12), .FIFO_LOG2(4), .PRIME(8), .OFFSET_BIN(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .dac_stb(dac_stb), .dac_data(dac_data1), .dac_active(dac_active1),
    .fill(fill1), .ovf_cnt(ovf1), .udf_cnt(udf1), .clr_cnt(clr_cnt));

  always #5 clk = ~clk;

  task automatic model_clear();
    q.delete();
    m_run = 0; m_ovf = 0; m_udf = 0;
    m_dac0 = 12'h800; m_dac1 = 12'h000;
  endtask

  // Drive one cycle of inputs, advance the clock, update the model, settle.
  task automatic step(input bit v, input logic [11:0] d, input bit s, input bit c);
    bit pop, udf;
    logic [11:0] x;
    in_valid = v; in_data = d; dac_stb = s; clr_cnt = c;
    @(posedge clk);
    pop = s && (m_run ? (q.size() > 0) : (q.size() >= PRIME));
    udf = s && m_run && (q.size() == 0);
    if (pop) begin
      x = q.pop_front();
      m_dac1 = x;
      m_dac0 = x ^ 12'h800;
      m_run = 1;
    end
    if (udf) begin
      m_dac1 = 12'h000; m_dac0 = 12'h800; m_run = 0;
    end
    if (v) begin
      if (q.size() < DEPTH) q.push_back(d);
      else if (m_ovf < 65535) m_ovf++;
    end
    if (udf && m_udf < 65535) m_udf++;
    if (c) begin m_ovf = 0; m_udf = 0; end
    #1;
  endtask

  task automatic apply_reset();
    in_valid = 0; dac_stb = 0; clr_cnt = 0; in_data = '0;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    model_clear();
  endtask

  task automatic test_reset();
    // run a little traffic first so reset must actually discard state
    rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1; in_data = 12'(i); @(posedge clk); #1;
    end
    in_valid = 0;
    rst_n = 0; #1;
    tests++; if (fill0 !== 5'd0) begin fails++; $display("FAIL reset_async_fill got %0d exp 0", fill0); end
    tests++; if (dac_data0 !== 12'h800) begin fails++; $display("FAIL reset_async_dac0 got %h exp 800", dac_data0); end
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    model_clear();
    for (int i = 0; i < 16; i++) begin
      step(0, 12'h0, (i % 4) == 0, 0);
      tests++; if (dac_data0 !== 12'h800) begin fails++; $display("FAIL reset_dac0 cyc %0d got %h exp 800", i, dac_data0); end
      tests++; if (dac_data1 !== 12'h000) begin fails++; $display("FAIL reset_dac1 cyc %0d got %h exp 000", i, dac_data1); end
      tests++; if (dac_active0 !== 1'b0) begin fails++; $display("FAIL reset_active cyc %0d got %b exp 0", i, dac_active0); end
      tests++; if (fill0 !== 5'd0) begin fails++; $display("FAIL reset_fill cyc %0d got %0d exp 0", i, fill0); end
      tests++; if (ovf0 !== 16'd0 || udf0 !== 16'd0) begin fails++; $display("FAIL reset_cnt cyc %0d got ovf %0d udf %0d exp 0 0", i, ovf0, udf0); end
    end
  endtask

  task automatic test_prime_playout_underflow();
    apply_reset();
    for (int i = 1; i <= 8; i++) step(1, 12'(i), 0, 0);
    tests++; if (fill0 !== 5'd8) begin fails++; $display("FAIL prime_fill got %0d exp 8", fill0); end
    tests++; if (dac_active0 !== 1'b0) begin fails++; $display("FAIL prime_active got %b exp 0", dac_active0); end
    for (int i = 1; i <= 8; i++) begin
      step(0, 12'h0, 1, 0);
      tests++; if (dac_data0 !== 12'h800 + 12'(i)) begin fails++; $display("FAIL play_dac0 n %0d got %h exp %h", i, dac_data0, 12'h800 + 12'(i)); end
      tests++; if (dac_data1 !== 12'(i)) begin fails++; $display("FAIL play_dac1 n %0d got %h exp %h", i, dac_data1, 12'(i)); end
      tests++; if (dac_active0 !== 1'b1) begin fails++; $display("FAIL play_active n %0d got %b exp 1", i, dac_active0); end
      step(0, 12'h0, 0, 0);
      tests++; if (dac_data0 !== 12'h800 + 12'(i)) begin fails++; $display("FAIL play_hold n %0d got %h exp %h", i, dac_data0, 12'h800 + 12'(i)); end
    end
    step(0, 12'h0, 1, 0);
    tests++; if (dac_data0 !== 12'h800) begin fails++; $display("FAIL udf_dac0 got %h exp 800", dac_data0); end
    tests++; if (udf0 !== 16'd1) begin fails++; $display("FAIL udf_cnt got %0d exp 1", udf0); end
    tests++; if (dac_active0 !== 1'b0) begin fails++; $display("FAIL udf_active got %b exp 0", dac_active0); end
    step(1, 12'h055, 0, 0);
    step(0, 12'h0, 1, 0);
    tests++; if (dac_data0 !== 12'h800 || dac_active0 !== 1'b0) begin fails++; $display("FAIL reprime_hold got %h/%b exp 800/0", dac_data0, dac_active0); end
    tests++; if (fill0 !== 5'd1) begin fails++; $display("FAIL reprime_fill got %0d exp 1", fill0); end
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int i = 0; i < 20; i++) step(1, 12'(i), 0, 0);
    tests++; if (fill0 !== 5'd16) begin fails++; $display("FAIL ovf_fill got %0d exp 16", fill0); end
    tests++; if (ovf0 !== 16'd4) begin fails++; $display("FAIL ovf_cnt got %0d exp 4", ovf0); end
    for (int i = 0; i < 16; i++) begin
      step(0, 12'h0, 1, 0);
      tests++; if (dac_data0 !== 12'h800 + 12'(i)) begin fails++; $display("FAIL ovf_play n %0d got %h exp %h", i, dac_data0, 12'h800 + 12'(i)); end
    end
    tests++; if (fill0 !== 5'd0) begin fails++; $display("FAIL ovf_drain got %0d exp 0", fill0); end
  endtask

  task automatic test_full_push_pop();
    apply_reset();
    for (int i = 0; i < 16; i++) step(1, 12'h100 + 12'(i), 0, 0);
    step(0, 12'h0, 1, 0);
    step(1, 12'h200, 0, 0);
    tests++; if (fill0 !== 5'd16 || dac_active0 !== 1'b1) begin fails++; $display("FAIL fpp_pre got fill %0d act %b exp 16 1", fill0, dac_active0); end
    step(1, 12'h300, 1, 0);
    tests++; if (fill0 !== 5'd16) begin fails++; $display("FAIL fpp_fill got %0d exp 16", fill0); end
    tests++; if (ovf0 !== 16'd0) begin fails++; $display("FAIL fpp_ovf got %0d exp 0", ovf0); end
    for (int i = 1; i <= 16; i++) begin
      step(0, 12'h0, 1, 0);
      tests++; if (dac_data0 !== m_dac0) begin fails++; $display("FAIL fpp_seq n %0d got %h exp %h", i, dac_data0, m_dac0); end
    end
    tests++; if (dac_data0 !== 12'hB00 || dac_data1 !== 12'h300) begin fails++; $display("FAIL fpp_last got %h/%h exp B00/300", dac_data0, dac_data1); end
  endtask

  task automatic test_offset_and_clear();
    apply_reset();
    for (int i = 0; i < 8; i++) step(1, 12'hFFF, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step(0, 12'h0, 1, 0);
      tests++; if (dac_data1 !== 12'hFFF || dac_data0 !== 12'h7FF) begin fails++; $display("FAIL neg_one n %0d got %h/%h exp 7FF/FFF", i, dac_data0, dac_data1); end
    end
    step(0, 12'h0, 1, 1);
    tests++; if (udf0 !== 16'd0 || udf1 !== 16'd0) begin fails++; $display("FAIL clr_wins got %0d/%0d exp 0", udf0, udf1); end
    tests++; if (dac_data1 !== 12'h000 || dac_data0 !== 12'h800) begin fails++; $display("FAIL udf_zero got %h/%h exp 800/000", dac_data0, dac_data1); end
    step(0, 12'h0, 1, 0);
    tests++; if (udf0 !== 16'd0 || dac_active0 !== 1'b0) begin fails++; $display("FAIL idle_no_udf got %0d/%b exp 0/0", udf0, dac_active0); end
  endtask

  task automatic test_random();
    int pv, ps;
    apply_reset();
    for (int i = 0; i < 4000; i++) begin
      if (i % 500 == 0) begin
        pv = $urandom_range(10, 95);
        ps = $urandom_range(10, 95);
      end
      step(($urandom % 100) < pv, 12'($urandom), ($urandom % 100) < ps, ($urandom % 400) == 0);
      tests++; if (dac_data0 !== m_dac0) begin fails++; $display("FAIL rand_dac0 cyc %0d got %h exp %h", i, dac_data0, m_dac0); end
      tests++; if (dac_data1 !== m_dac1) begin fails++; $display("FAIL rand_dac1 cyc %0d got %h exp %h", i, dac_data1, m_dac1); end
      tests++; if (dac_active0 !== m_run) begin fails++; $display("FAIL rand_active cyc %0d got %b exp %b", i, dac_active0, m_run); end
      tests++; if (int'(fill0) != q.size()) begin fails++; $display("FAIL rand_fill cyc %0d got %0d exp %0d", i, fill0, q.size()); end
      tests++; if (int'(ovf0) != m_ovf) begin fails++; $display("FAIL rand_ovf cyc %0d got %0d exp %0d", i, ovf0, m_ovf); end
      tests++; if (int'(udf0) != m_udf) begin fails++; $display("FAIL rand_udf cyc %0d got %0d exp %0d", i, udf0, m_udf); end
    end
  endtask

  task automatic test_ovf_saturate();
    apply_reset();
    for (int i = 0; i < 16 + 65534; i++) step(1, 12'h0AA, 0, 0);
    tests++; if (ovf0 !== 16'hFFFE) begin fails++; $display("FAIL sat_pre got %h exp FFFE", ovf0); end
    for (int i = 0; i < 6; i++) step(1, 12'h0AA, 0, 0);
    tests++; if (ovf0 !== 16'hFFFF || ovf1 !== 16'hFFFF) begin fails++; $display("FAIL sat_hold got %h/%h exp FFFF", ovf0, ovf1); end
    step(1, 12'h0AA, 0, 1);
    tests++; if (ovf0 !== 16'h0000) begin fails++; $display("FAIL sat_clr got %h exp 0000", ovf0); end
    step(1, 12'h0AA, 0, 0);
    tests++; if (ovf0 !== 16'h0001) begin fails++; $display("FAIL sat_restart got %h exp 0001", ovf0); end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_prime_playout_underflow();
    test_overflow();
    test_full_push_pop();
    test_offset_and_clear();
    test_random();
    test_ovf_saturate();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
